imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the instruction fetch path. Fills the word-addressed instruction memory from a byte stream after reset.
- Holds the CPU (via `cpu_hold`) until the program image is fully written, then releases it.
- Sits between a boot byte source (UART/testbench) and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width (depth 2^ADDR_WIDTH = 1024 words)
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; restarts a load from DONE or ERR
- in_valid  input  1  byte source has a byte
- in_data  input  8  byte payload
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write enable, one-cycle pulse
- mem_addr  output  ADDR_WIDTH  word address of write
- mem_wdata  output  32  instruction word to write
- cpu_hold  output  1  keep PC/fetch in reset while high
- done  output  1  image loaded successfully
- error  output  1  load aborted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named `clk` and `rst`.
- Reset values:
  - state = HDR, in_ready = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 1, done = 0, error = 0.
  - Byte counter and word count cleared.
- Handshake: a byte is accepted at a rising edge when in_valid && in_ready. in_data is ignored otherwise.
- Byte order: little-endian. The first accepted byte of a word goes to bits[7:0], the fourth to bits[31:24].
- States:
  - HDR:
    - in_ready = 1. Assemble 4 bytes into word count N (32-bit).
    - N == 0 → DONE.
    - N > 2^ADDR_WIDTH → ERR.
    - Otherwise → LOAD, with the address counter at 0.
  - LOAD:
    - in_ready = 1. Assemble words.
    - On the edge accepting a word's 4th byte, register mem_wdata and mem_addr and set mem_we = 1 for exactly the following cycle.
    - The address then increments by 1.
    - After the N-th word's write pulse → DONE (or CHK when the optional feature is enabled).
  - DONE:
    - in_ready = 0, cpu_hold = 0, done = 1.
    - start → HDR, with cpu_hold = 1 and done = 0 on the next cycle.
  - ERR:
    - in_ready = 0, cpu_hold = 1, error = 1.
    - start → HDR, clearing error.
- Latency:
  - 4th byte accepted at edge k → mem_we high in cycle k+1; memory samples it at edge k+1.
  - done rises / cpu_hold falls one cycle after the last mem_we pulse.
- Back-to-back writes: minimum spacing of mem_we pulses is 4 cycles. No backpressure is needed in LOAD.
- Boundaries:
  - N == 2^ADDR_WIDTH is legal. The final write goes to address 2^ADDR_WIDTH−1; the address counter must not wrap before DONE.
  - A start pulse in HDR, LOAD or CHK is ignored.
  - in_valid gaps mid-word preserve the partial word.
  - Reset asserted mid-operation discards the partial word and any pending write; mem_we drops immediately (asynchronously).
- Arithmetic: the word count compare uses the full 32-bit N against the (ADDR_WIDTH+1)-bit constant 2^ADDR_WIDTH.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the N data words, state CHK assembles one trailer word.
  - The trailer must equal the mod-2^32 sum of all N data words (sum reset in HDR).
  - Match → DONE; mismatch → ERR.
  - For N == 0 the trailer is still required and must equal 0.
- Not defined: no CHK state and no sum register; LOAD → DONE directly.

Decomposition:
- Package imem_loader_pkg contains:
  - state encoding localparams: HDR, LOAD, CHK, DONE, ERR
  - BYTES_PER_WORD = 4
  - default ADDR_WIDTH
- Sub-module word_assembler:
  - 2-bit byte counter plus 32-bit shift/insert register.
  - Inputs: clk, rst, byte_en, byte_in, clear.
  - Outputs: word, word_valid (1-cycle pulse coincident with the edge after the 4th byte).
- The top-level FSM owns the address counter, word count, sum and outputs.

Test Plan:
- Basic load: bytes 02 00 00 00, 67 45 23 01, EF CD AB 89, in_valid held high → mem_we pulses at addr 0 with 0x01234567 and at addr 1 with 0x89ABCDEF; done=1 and cpu_hold=0 one cycle after the 2nd pulse.
- Empty image: header 00 00 00 00 → no mem_we; done=1 in the cycle after the 4th header byte.
- Oversize image (ADDR_WIDTH=10): header 01 04 00 00 (N=1025) → ERR, error=1, in_ready=0, no writes; start pulse → HDR, error=0, in_ready=1.
- Stalled source: same stream as the basic load with in_valid low for 3 cycles between every byte → identical writes and values; in_ready stays 1.
- Reset mid-load: after the header and 2 data bytes, pulse rst low between clock edges → all outputs at reset values immediately; a fresh load then writes from addr 0.
- With IMEM_LOADER_CHECKSUM_EN: N=2 image plus trailer 0x8ACF1356 → done=1; trailer 0x8ACF1357 → error=1, cpu_hold stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and sizing constants for the instruction memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    LOAD = 3'd1,
    CHK  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_ADDR_WIDTH = 10;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler. word/word_valid are presented during the
// cycle whose rising edge accepts the 4th byte, so the consumer registers the word on that edge.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    low_bytes[7:0]   <= byte_in;
        2'd1:    low_bytes[15:8]  <= byte_in;
        2'd2:    low_bytes[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The top byte is never stored: it is consumed straight off the bus.
  assign word       = {byte_in, low_bytes};
  assign word_valid = byte_en && !clear && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a byte stream and holds the CPU until done.
// Optional trailer checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CHK;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t              state_q, state_d;
  logic                byte_en, asm_clear, word_valid, last_word_in;
  logic [31:0]         word;
  logic [ADDR_WIDTH:0] word_idx, word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         sum_q;
`endif

  assign byte_en      = in_valid && in_ready;
  assign last_word_in = (word_idx == word_count);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .clear      (asm_clear),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HDR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    asm_clear = 1'b0;
    case (state_q)
      HDR: begin
        in_ready = 1'b1;
        if (word_valid) begin
          if (word == 32'd0)          state_d = POST_DATA;
          else if (word > MAX_WORDS)  state_d = ERR;
          else                        state_d = LOAD;
        end
      end
      LOAD: begin
        // Stop taking bytes once all words are in; the final write is still in flight.
        in_ready = !last_word_in;
        if (mem_we && last_word_in) state_d = POST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (word_valid) state_d = (word == sum_q) ? DONE : ERR;
      end
`endif
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) begin
          state_d   = HDR;
          asm_clear = 1'b1;
        end
      end
      ERR: begin
        error = 1'b1;
        if (start) begin
          state_d   = HDR;
          asm_clear = 1'b1;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_idx   <= '0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (state_q == HDR) begin
        word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q    <= 32'd0;
`endif
        if (word_valid) word_count <= word[ADDR_WIDTH:0];
      end
      if (state_q == LOAD && word_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= word_idx[ADDR_WIDTH-1:0];
        mem_wdata <= word;
        word_idx  <= word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q     <= sum_q + word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic/empty/oversize/stalled/reset/full-depth loads.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  int            checks = 0;
  int            failures = 0;
  int            wr_n = 0;
  logic [AW-1:0] wr_addr [0:2047];
  logic [31:0]   wr_data [0:2047];
  bit            ready_drop;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always @(negedge clk) begin
    if (mem_we && wr_n < 2048) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      if (!in_ready) ready_drop = 1'b1;
      @(negedge clk);
    end
    if (!in_ready) ready_drop = 1'b1;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hold_done_err", {29'd0, cpu_hold, done, error}, 32'b100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // basic load
    send_word(32'd2, 0);
    send_word(32'h0123_4567, 0);
    send_word(32'h89AB_CDEF, 0);
    chk("basic_we", 32'(mem_we), 32'd1);
    chk("basic_addr1", 32'(mem_addr), 32'd1);
    chk("basic_data1", mem_wdata, 32'h89AB_CDEF);
    chk("basic_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("basic_done", {30'd0, done, cpu_hold}, 32'b10);
    chk("basic_in_ready", 32'(in_ready), 32'd0);
    chk("basic_wr_n", 32'(wr_n), 32'd2);
    chk("basic_w0", {22'd0, wr_addr[0]} ^ wr_data[0], 32'h0123_4567);
    chk("basic_w1", {22'd0, wr_addr[1]} ^ wr_data[1], 32'h89AB_CDEE);

    pulse_start();
    chk("restart", {29'd0, cpu_hold, done, in_ready}, 32'b101);

    // empty image
    send_word(32'd0, 0);
    chk("empty_done", {30'd0, done, cpu_hold}, 32'b10);
    pulse_start();

    // oversize image, N = 1025
    send_word(32'h0000_0401, 0);
    chk("over_err", {29'd0, error, in_ready, cpu_hold}, 32'b101);
    pulse_start();
    chk("over_clear", {30'd0, error, in_ready}, 32'b01);
    chk("over_no_wr", 32'(wr_n), 32'd2);

    // stalled source
    ready_drop = 1'b0;
    send_word(32'd2, 3);
    send_word(32'h0123_4567, 3);
    send_word(32'h89AB_CDEF, 3);
    chk("stall_ready", 32'(ready_drop), 32'd0);
    @(negedge clk);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_wr_n", 32'(wr_n), 32'd4);
    chk("stall_w0", wr_data[2], 32'h0123_4567);
    chk("stall_w1", wr_data[3], 32'h89AB_CDEF);
    chk("stall_addr", {16'd0, 6'd0, wr_addr[2][4:0], wr_addr[3][4:0]}, 32'h1);

    // reset mid-load
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h67, 0);
    send_byte(8'h45, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out", {27'd0, in_ready, mem_we, cpu_hold, done, error}, 32'b10100);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_word(32'd1, 0);
    pulse_start();
    chk("start_in_load", {30'd0, done, cpu_hold}, 32'b01);
    send_word(32'h1234_5678, 0);
    chk("fresh_addr", 32'(mem_addr), 32'd0);
    chk("fresh_data", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_wr_n", 32'(wr_n), 32'd5);

    // full depth, N = 1024
    pulse_start();
    send_word(32'd1024, 0);
    for (int i = 0; i < 1024; i++) send_word(32'(i) ^ 32'hC0DE_0000, 0);
    chk("full_addr", 32'(mem_addr), 32'd1023);
    chk("full_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("full_done", {30'd0, done, cpu_hold}, 32'b10);
    chk("full_wr_n", 32'(wr_n), 32'd1029);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wr_n == 1029 && (32'(wr_addr[5+i]) !== 32'(i) || wr_data[5+i] !== (32'(i) ^ 32'hC0DE_0000)))
        bad++;
    chk("full_seq", 32'(bad), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h0123_4567, 0);
    send_word(32'h89AB_CDEF, 0);
    @(negedge clk);
    send_word(32'h8ACF_1356, 0);
    chk("csum_ok", {29'd0, done, error, cpu_hold}, 32'b100);
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h0123_4567, 0);
    send_word(32'h89AB_CDEF, 0);
    @(negedge clk);
    send_word(32'h8ACF_1357, 0);
    chk("csum_bad", {29'd0, done, error, cpu_hold}, 32'b011);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
